// File: rtl/arrow_pool.sv
// Multi-slot arrow manager: spawns arrows through a valid/ready handshake, advances
// them once per frame toward the player, resolves shield blocks / hits, and renders them.
module arrow_pool #(
  parameter int          N_ARROWS   = 4,
  parameter int          WIDTH      = 8,
  parameter int          HEIGHT     = 32,
  parameter int          CX         = 512,
  parameter int          CY         = 384,
  parameter int          START_DIST = 384,
  parameter int          SHIELD_LO  = 64,
  parameter int          SHIELD_HI  = 96,
  parameter logic [11:0] COLOR_V    = 12'hF00,
  parameter logic [11:0] COLOR_H    = 12'h0CF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [10:0]                       hcount_in,
  input  logic [9:0]                        vcount_in,
  input  logic                              spawn_valid,
  input  logic [1:0]                        spawn_dir,
  input  logic [2:0]                        spawn_speed,
  output logic                              spawn_ready,
  input  logic [1:0]                        shield_dir_in,
  output logic [11:0]                       pixel_out,
  output logic                              valid_out,
  output logic                              blocked,
  output logic                              hit_player,
  output logic [$clog2(N_ARROWS+1)-1:0]     hit_count,
  output logic [$clog2(N_ARROWS+1)-1:0]     active_count
);

  localparam int CW = $clog2(N_ARROWS + 1);
  localparam int IW = (N_ARROWS > 1) ? $clog2(N_ARROWS) : 1;

  localparam logic [9:0]  START_10 = 10'(START_DIST);
  localparam logic [9:0]  LO_10    = 10'(SHIELD_LO);
  localparam logic [9:0]  HI_10    = 10'(SHIELD_HI);
  localparam logic [10:0] CX_11    = 11'(CX);
  localparam logic [10:0] CY_11    = 11'(CY);
  localparam logic [10:0] W_11     = 11'(WIDTH);
  localparam logic [10:0] H_11     = 11'(HEIGHT);

  typedef enum logic [1:0] {
    DIR_TOP    = 2'd0,
    DIR_BOTTOM = 2'd1,
    DIR_LEFT   = 2'd2,
    DIR_RIGHT  = 2'd3
  } dir_e;

  logic [N_ARROWS-1:0] active_q, active_d;
  dir_e                dir_q   [N_ARROWS];
  dir_e                dir_d   [N_ARROWS];
  logic [2:0]          speed_q [N_ARROWS];
  logic [2:0]          speed_d [N_ARROWS];
  logic [9:0]          dist_q  [N_ARROWS];
  logic [9:0]          dist_d  [N_ARROWS];

  logic          blocked_q, blocked_d;
  logic          hit_player_q, hit_player_d;
  logic [CW-1:0] hit_count_q, hit_count_d;

  logic          tick;
  logic [9:0]    d_next [N_ARROWS];
  logic [IW-1:0] free_idx;

  assign tick        = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign spawn_ready = |(~active_q);

  always_comb begin
    for (int i = 0; i < N_ARROWS; i++) begin
      d_next[i] = (dist_q[i] > {7'd0, speed_q[i]}) ? dist_q[i] - {7'd0, speed_q[i]} : 10'd0;
    end
  end

  // Lowest-index free slot; the descending scan lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int i = N_ARROWS - 1; i >= 0; i--) begin
      if (!active_q[i]) free_idx = IW'(i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    active_d     = active_q;
    dir_d        = dir_q;
    speed_d      = speed_q;
    dist_d       = dist_q;
    blocked_d    = 1'b0;
    hit_player_d = 1'b0;
    hit_count_d  = '0;

    if (tick) begin
      for (int i = 0; i < N_ARROWS; i++) begin
        if (active_q[i]) begin
          if ((dir_q[i] == dir_e'(shield_dir_in)) && (d_next[i] >= LO_10) && (d_next[i] <= HI_10)) begin
            active_d[i] = 1'b0;
            blocked_d   = 1'b1;
          end else if (d_next[i] == 10'd0) begin
            active_d[i]  = 1'b0;
            hit_player_d = 1'b1;
            hit_count_d  = hit_count_d + CW'(1);
          end else begin
            dist_d[i] = d_next[i];
          end
        end
      end
    end

    // The chosen slot was free before the tick, so it never collides with the advance above.
    if (spawn_valid && spawn_ready) begin
      active_d[free_idx] = 1'b1;
      dir_d[free_idx]    = dir_e'(spawn_dir);
      speed_d[free_idx]  = spawn_speed;
      dist_d[free_idx]   = START_10;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= '0;
      blocked_q    <= 1'b0;
      hit_player_q <= 1'b0;
      hit_count_q  <= '0;
    end else begin
      active_q     <= active_d;
      blocked_q    <= blocked_d;
      hit_player_q <= hit_player_d;
      hit_count_q  <= hit_count_d;
    end
  end

  // NOTE: slot payload is left unreset; it is only ever observed through active_q.
  always_ff @(posedge clk) begin
    dir_q   <= dir_d;
    speed_q <= speed_d;
    dist_q  <= dist_d;
  end

  assign blocked    = blocked_q;
  assign hit_player = hit_player_q;
  assign hit_count  = hit_count_q;

  always_comb begin
    active_count = '0;
    for (int i = 0; i < N_ARROWS; i++) begin
      if (active_q[i]) active_count = active_count + CW'(1);
    end
  end

  logic [10:0] pos_x [N_ARROWS];
  logic [10:0] pos_y [N_ARROWS];
  logic [10:0] v_11;
  logic [N_ARROWS-1:0] covers;
  logic [N_ARROWS-1:0] is_vert;

  assign v_11 = {1'b0, vcount_in};

  always_comb begin
    for (int i = 0; i < N_ARROWS; i++) begin
      pos_x[i]   = CX_11;
      pos_y[i]   = CY_11;
      is_vert[i] = (dir_q[i] == DIR_TOP) || (dir_q[i] == DIR_BOTTOM);
      case (dir_q[i])
        DIR_TOP:    pos_y[i] = CY_11 - {1'b0, dist_q[i]};
        DIR_BOTTOM: pos_y[i] = CY_11 + {1'b0, dist_q[i]};
        DIR_LEFT:   pos_x[i] = CX_11 - {1'b0, dist_q[i]};
        default:    pos_x[i] = CX_11 + {1'b0, dist_q[i]};
      endcase
      if (is_vert[i]) begin
        covers[i] = active_q[i]
                    && (hcount_in >= pos_x[i]) && (hcount_in < pos_x[i] + W_11)
                    && (v_11 >= pos_y[i])      && (v_11 < pos_y[i] + H_11);
      end else begin
        covers[i] = active_q[i]
                    && (hcount_in >= pos_x[i]) && (hcount_in < pos_x[i] + H_11)
                    && (v_11 >= pos_y[i])      && (v_11 < pos_y[i] + W_11);
      end
    end
  end

  always_comb begin
    pixel_out = 12'h000;
    for (int i = N_ARROWS - 1; i >= 0; i--) begin
      if (covers[i]) pixel_out = is_vert[i] ? COLOR_V : COLOR_H;
    end
  end

  assign valid_out = |covers;

endmodule
